// File: rtl/tt_um_q5wan_4_bit_alu_pkg.sv
// rtl/tt_um_q5wan_4_bit_alu_pkg.sv - opcodes and flag positions for the 4-bit ALU tile
package tt_um_q5wan_4_bit_alu_pkg;

   localparam logic [3:0] OP_ADD = 4'h0;
   localparam logic [3:0] OP_ADC = 4'h1;
   localparam logic [3:0] OP_SUB = 4'h2;
   localparam logic [3:0] OP_SBB = 4'h3;
   localparam logic [3:0] OP_AND = 4'h4;
   localparam logic [3:0] OP_OR  = 4'h5;
   localparam logic [3:0] OP_XOR = 4'h6;
   localparam logic [3:0] OP_NOT = 4'h7;
   localparam logic [3:0] OP_SHL = 4'h8;
   localparam logic [3:0] OP_SHR = 4'h9;
   localparam logic [3:0] OP_ASR = 4'hA;
   localparam logic [3:0] OP_ROL = 4'hB;
   localparam logic [3:0] OP_ROR = 4'hC;
   localparam logic [3:0] OP_INC = 4'hD;
   localparam logic [3:0] OP_DEC = 4'hE;
   localparam logic [3:0] OP_CMP = 4'hF;

   localparam int FLAG_C = 4;
   localparam int FLAG_Z = 5;
   localparam int FLAG_N = 6;
   localparam int FLAG_V = 7;

endpackage

// File: rtl/tt_um_q5wan_4_bit_alu_core.sv
// rtl/tt_um_q5wan_4_bit_alu_core.sv - combinational 4-bit ALU datapath with C/Z/N/V flags
module alu4_core
   import tt_um_q5wan_4_bit_alu_pkg::*;
(
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic [3:0] i_op,
   input  logic       i_cin,
   output logic [3:0] o_r,
   output logic       o_c,
   output logic       o_z,
   output logic       o_n,
   output logic       o_v
);

   logic [3:0] w_addend;
   logic [3:0] w_subtr;
   logic       w_cy;
   logic       w_bw;
   logic [4:0] w_sum;
   logic [4:0] w_diff;
   logic       w_add_v;
   logic       w_sub_v;
   logic [3:0] w_r;
   logic       w_c;
   logic       w_v;
   logic       w_is_cmp;

   // INC/DEC share the adder/subtractor with a constant second operand.
   assign w_addend = (i_op == OP_INC) ? 4'd1 : i_b;
   assign w_subtr  = (i_op == OP_DEC) ? 4'd1 : i_b;
   assign w_cy     = (i_op == OP_ADC) & i_cin;
   assign w_bw     = (i_op == OP_SBB) & i_cin;
   assign w_sum    = {1'b0, i_a} + {1'b0, w_addend} + {4'd0, w_cy};
   assign w_diff   = {1'b0, i_a} - {1'b0, w_subtr} - {4'd0, w_bw};
   assign w_add_v  = (i_a[3] == w_addend[3]) && (w_sum[3] != i_a[3]);
   assign w_sub_v  = (i_a[3] != w_subtr[3]) && (w_diff[3] != i_a[3]);
   assign w_is_cmp = (i_op == OP_CMP);

   always_comb begin
      w_r = 4'd0;
      w_c = 1'b0;
      w_v = 1'b0;
      case (i_op)
         OP_ADD, OP_ADC, OP_INC: begin
            w_r = w_sum[3:0];
            w_c = w_sum[4];
            w_v = w_add_v;
         end
         OP_SUB, OP_SBB, OP_DEC: begin
            w_r = w_diff[3:0];
            w_c = ~w_diff[4];
            w_v = w_sub_v;
         end
         OP_AND: w_r = i_a & i_b;
         OP_OR:  w_r = i_a | i_b;
         OP_XOR: w_r = i_a ^ i_b;
         OP_NOT: w_r = ~i_a;
         OP_SHL: begin w_r = {i_a[2:0], 1'b0};   w_c = i_a[3]; end
         OP_SHR: begin w_r = {1'b0, i_a[3:1]};   w_c = i_a[0]; end
         OP_ASR: begin w_r = {i_a[3], i_a[3:1]}; w_c = i_a[0]; end
         OP_ROL: begin w_r = {i_a[2:0], i_a[3]}; w_c = i_a[3]; end
         OP_ROR: begin w_r = {i_a[0], i_a[3:1]}; w_c = i_a[0]; end
         OP_CMP: begin
            w_r = i_a;
            w_c = ~w_diff[4];
            w_v = w_sub_v;
         end
         default: w_r = 4'd0;
      endcase
   end

   // CMP passes A through but reports Z/N of the difference.
   assign o_r = w_r;
   assign o_c = w_c;
   assign o_v = w_v;
   assign o_z = w_is_cmp ? (w_diff[3:0] == 4'd0) : (w_r == 4'd0);
   assign o_n = w_is_cmp ? w_diff[3] : w_r[3];

endmodule

// File: rtl/tt_um_q5wan_4_bit_alu.sv
// rtl/tt_um_q5wan_4_bit_alu.sv - Tiny Tapeout top: pin mapping and registered ALU output
module tt_um_q5wan_4_bit_alu
   import tt_um_q5wan_4_bit_alu_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [3:0] w_r;
   logic       w_c;
   logic       w_z;
   logic       w_n;
   logic       w_v;
   logic [7:0] w_next;
   logic [7:0] r_out;
   logic       w_unused;

   alu4_core u_core (
      .i_a   (ui_in[3:0]),
      .i_b   (ui_in[7:4]),
      .i_op  (uio_in[3:0]),
      .i_cin (uio_in[4]),
      .o_r   (w_r),
      .o_c   (w_c),
      .o_z   (w_z),
      .o_n   (w_n),
      .o_v   (w_v)
   );

   always_comb begin
      w_next         = 8'd0;
      w_next[3:0]    = w_r;
      w_next[FLAG_C] = w_c;
      w_next[FLAG_Z] = w_z;
      w_next[FLAG_N] = w_n;
      w_next[FLAG_V] = w_v;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out <= 8'd0;
      end else if (ena) begin
         r_out <= w_next;
      end
   end

   assign uo_out   = r_out;
   assign uio_out  = 8'd0;
   assign uio_oe   = 8'd0;
   assign w_unused = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_tt_um_q5wan_4_bit_alu.sv
// tb/tb_tt_um_q5wan_4_bit_alu.sv - self-checking scoreboard bench for the 4-bit ALU tile
module tb_tt_um_q5wan_4_bit_alu;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_tests;
   int n_fail;
   logic [7:0] sb_q[$];
   logic [7:0] last_exp;
   logic [7:0] exp_v;

   tt_um_q5wan_4_bit_alu dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference built from integer arithmetic and signed range checks.
   function automatic logic [7:0] model(input logic [7:0] ui, input logic [7:0] uio);
      int a, b, ci, sa, sb, t, s, r, cf, vf, zf, nf, op;
      a  = int'(ui[3:0]);
      b  = int'(ui[7:4]);
      ci = int'(uio[4]);
      op = int'(uio[3:0]);
      sa = (a >= 8) ? a - 16 : a;
      sb = (b >= 8) ? b - 16 : b;
      cf = 0; vf = 0; r = 0;
      case (op)
         0:  begin t = a + b;      s = sa + sb;      r = t & 15; cf = (t > 15); vf = (s > 7 || s < -8); end
         1:  begin t = a + b + ci; s = sa + sb + ci; r = t & 15; cf = (t > 15); vf = (s > 7 || s < -8); end
         2:  begin t = a - b;      s = sa - sb;      r = t & 15; cf = (t >= 0); vf = (s > 7 || s < -8); end
         3:  begin t = a - b - ci; s = sa - sb - ci; r = t & 15; cf = (t >= 0); vf = (s > 7 || s < -8); end
         4:  r = a & b;
         5:  r = a | b;
         6:  r = a ^ b;
         7:  r = 15 - a;
         8:  begin r = (a * 2) & 15;            cf = a / 8; end
         9:  begin r = a / 2;                   cf = a % 2; end
         10: begin r = (a / 2) + ((a >= 8) ? 8 : 0); cf = a % 2; end
         11: begin r = ((a * 2) & 15) + a / 8;  cf = a / 8; end
         12: begin r = a / 2 + (a % 2) * 8;     cf = a % 2; end
         13: begin t = a + 1; s = sa + 1; r = t & 15; cf = (t > 15); vf = (s > 7); end
         14: begin t = a - 1; s = sa - 1; r = t & 15; cf = (t >= 0); vf = (s < -8); end
         default: begin t = a - b; s = sa - sb; r = a; cf = (t >= 0); vf = (s > 7 || s < -8); end
      endcase
      zf = (r == 0) ? 1 : 0;
      nf = (r >= 8) ? 1 : 0;
      if (op == 15) begin
         zf = (a == b) ? 1 : 0;
         nf = (((a - b) & 15) >= 8) ? 1 : 0;
      end
      model = {vf[0], nf[0], zf[0], cf[0], r[3:0]};
   endfunction

   task automatic apply(input logic [7:0] ui, input logic [7:0] uio, input logic en);
      @(negedge clk);
      ui_in  = ui;
      uio_in = uio;
      ena    = en;
      if (en) last_exp = model(ui, uio);
      sb_q.push_back(last_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h89;
      uio_in = 8'h00;
      #3;
      n_tests++;
      if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_uo_out actual=%h required=00", uo_out); end
      @(posedge clk); #1;
      n_tests++;
      if (uo_out !== 8'h00) begin n_fail++; $display("FAIL reset_hold_over_edge actual=%h required=00", uo_out); end
      n_tests++;
      if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
         n_fail++; $display("FAIL reset_uio actual=%h/%h required=00/00", uio_out, uio_oe);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = 8'h00;
   endtask

   task automatic test_plan_vectors();
      logic [7:0] vec_ui[6]  = '{8'h89, 8'h53, 8'h3C, 8'h0F, 8'h01, 8'h55};
      logic [7:0] vec_uio[6] = '{8'h00, 8'h02, 8'h04, 8'h11, 8'h0C, 8'h0F};
      logic [7:0] vec_exp[6] = '{8'h91, 8'h4E, 8'h20, 8'h30, 8'h58, 8'h35};
      for (int i = 0; i < 6; i++) begin
         apply(vec_ui[i], vec_uio[i], 1'b1);
         exp_v = sb_q.pop_front();
         n_tests++;
         if (uo_out !== exp_v) begin n_fail++; $display("FAIL plan_vec%0d_model actual=%h required=%h", i, uo_out, exp_v); end
         n_tests++;
         if (uo_out !== vec_exp[i]) begin n_fail++; $display("FAIL plan_vec%0d_const actual=%h required=%h", i, uo_out, vec_exp[i]); end
      end
   endtask

   task automatic test_all_opcodes();
      logic [7:0] ops_ui[4] = '{8'h00, 8'h78, 8'h8F, 8'hA5};
      for (int k = 0; k < 4; k++) begin
         for (int op = 0; op < 16; op++) begin
            apply(ops_ui[k], {3'b000, k[0], op[3:0]}, 1'b1);
            exp_v = sb_q.pop_front();
            n_tests++;
            if (uo_out !== exp_v) begin
               n_fail++; $display("FAIL opcode_%0h_ui%h actual=%h required=%h", op, ops_ui[k], uo_out, exp_v);
            end
         end
      end
   endtask

   task automatic test_enable_hold();
      apply(8'h89, 8'h00, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++;
      if (uo_out !== 8'h91) begin n_fail++; $display("FAIL hold_load actual=%h required=91", uo_out); end
      for (int i = 0; i < 3; i++) begin
         apply(8'h53 + 8'(i), 8'h02 + 8'(i), 1'b0);
         exp_v = sb_q.pop_front();
         n_tests++;
         if (uo_out !== 8'h91 || uo_out !== exp_v) begin
            n_fail++; $display("FAIL hold_edge%0d actual=%h required=91", i, uo_out);
         end
      end
   endtask

   task automatic test_async_reset();
      apply(8'h89, 8'h00, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++;
      if (uo_out !== 8'h91) begin n_fail++; $display("FAIL areset_preload actual=%h required=91", uo_out); end
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if (uo_out !== 8'h00) begin n_fail++; $display("FAIL areset_immediate actual=%h required=00", uo_out); end
      n_tests++;
      if (uio_oe !== 8'h00 || uio_out !== 8'h00) begin
         n_fail++; $display("FAIL areset_uio actual=%h/%h required=00/00", uio_oe, uio_out);
      end
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = 8'h00;
      apply(8'h89, 8'h00, 1'b1);
      exp_v = sb_q.pop_front();
      n_tests++;
      if (uo_out !== 8'h91) begin n_fail++; $display("FAIL areset_release actual=%h required=91", uo_out); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] rui, ruio;
      logic       ren;
      for (int i = 0; i < 300; i++) begin
         rui  = 8'($urandom);
         ruio = 8'($urandom);
         ren  = ($urandom_range(0, 3) != 0);
         apply(rui, ruio, ren);
         exp_v = sb_q.pop_front();
         n_tests++;
         if (uo_out !== exp_v || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
            n_fail++;
            $display("FAIL b2b_%0d ui=%h uio=%h ena=%b actual=%h required=%h", i, rui, ruio, ren, uo_out, exp_v);
         end
      end
   endtask

   initial begin
      n_tests  = 0;
      n_fail   = 0;
      last_exp = 8'h00;
      test_reset();
      test_plan_vectors();
      test_all_opcodes();
      test_enable_hold();
      test_async_reset();
      test_back_to_back();
      n_tests++;
      if (sb_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain actual=%0d required=0", sb_q.size()); end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_um_q5wan_4_bit_alu.md
# tt_um_q5wan_4_bit_alu

Registered 4-bit arithmetic/logic unit for a Tiny Tapeout tile. Two 4-bit operands arrive on the dedicated inputs, and a 4-bit opcode plus carry-in arrive on the bidirectional pins. On each enabled clock edge the block registers a 4-bit result and four status flags onto the dedicated outputs. It is the top level of the tile; the harness provides the clock, reset and enable.

## Interface
- No parameters.
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  design-selected enable; registers update only while high.
- ui_in  in  8  [3:0] operand A, [7:4] operand B.
- uio_in  in  8  [3:0] opcode, [4] carry-in (cin), [7:5] ignored.
- uo_out  out  8  [3:0] result R, [4] C, [5] Z, [6] N, [7] V.
- uio_out  out  8  constant 0.
- uio_oe  out  8  constant 0 (all bidirectional pins are inputs).

## Operation
- Opcodes:
  - 0 ADD: A+B.
  - 1 ADC: A+B+cin.
  - 2 SUB: A−B.
  - 3 SBB: A−B−cin.
  - 4 AND.
  - 5 OR.
  - 6 XOR.
  - 7 NOT A.
  - 8 SHL A.
  - 9 SHR A (logical).
  - A ASR A.
  - B ROL A.
  - C ROR A.
  - D INC A.
  - E DEC A.
  - F CMP: R=A, flags from A−B.
- Arithmetic is computed in 5 bits.
  - C for ADD/ADC/INC is the bit-4 carry-out.
  - C for SUB/SBB/DEC/CMP is NOT borrow (1 when no borrow).
- C for shifts and rotates is the bit shifted out: A[3] for SHL and ROL, A[0] for SHR, ASR and ROR.
- C = 0 for opcodes 4–7.
- V is two's-complement overflow for opcodes 0–3, D, E and F; V = 0 otherwise.
- Z = (R == 0). For CMP only, Z = (A == B).
- N = R[3]. For CMP only, N = bit 3 of A−B.
- B is ignored by opcodes 7–E. cin is ignored except by ADC and SBB.

## Timing
- Purely combinational compute; uo_out comes straight from an 8-bit register.
- Latency: one clock. Inputs sampled at rising edge k are visible on uo_out after edge k.
- With ena = 0 the register holds its value and inputs are ignored.
- rst_n low clears uo_out to 0x00 immediately, without a clock edge. This holds even mid-operation.
- Reset release: the first enabled edge after rst_n rises loads a fresh result.
- uio_out and uio_oe are 0 at all times, including during reset.
- There is no handshake: a new operation may start every cycle.

## Structure
- Shared package holds:
  - opcode localparams (OP_ADD … OP_CMP);
  - flag bit-position constants (FLAG_C=4, FLAG_Z=5, FLAG_N=6, FLAG_V=7).
- One combinational sub-module, alu4_core (A, B, op, cin → R, C, Z, N, V).
- The top level holds only the output register, enable/reset logic and pin mapping.

## Test plan
- ADD overflow: ui_in=0x89, uio_in=0x00, one edge → uo_out=0x91 (R=1, C=1, V=1).
- SUB with borrow: ui_in=0x53, uio_in=0x02 → uo_out=0x4E (R=E, N=1, C=0).
- AND to zero: ui_in=0x3C, uio_in=0x04 → uo_out=0x20. Also ADC: ui_in=0x0F, uio_in=0x11 → 0x30.
- ROR and CMP:
  - ROR: ui_in=0x01, uio_in=0x0C → uo_out=0x58.
  - CMP equal: ui_in=0x55, uio_in=0x0F → uo_out=0x35.
- Enable hold: load 0x91 with ena=1, then set ena=0 and change the inputs over 3 edges → uo_out stays 0x91.
- Async reset: with uo_out=0x91, drop rst_n between clock edges → uo_out=0x00 at once, uio_oe=0x00. Release, then one edge with ui_in=0x89, uio_in=0x00 → 0x91.
